// File: rtl/main_memory_block_fetch.sv
// Block-refill backing store behind the direct-mapped cache.
// Returns an aligned block after a fixed latency; accepts word stores.
module main_memory_block_fetch #(
    parameter int ADDR_WIDTH   = 15,
    parameter int WORD_SIZE    = 32,
    parameter int WORD_COUNT   = 4,
    parameter int READ_LATENCY = 4,
    parameter logic [WORD_SIZE-1:0] DATA_SEED = '0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            read_enable,
    input  logic [ADDR_WIDTH-1:0]           address,
    input  logic                            write_enable,
    input  logic [WORD_SIZE-1:0]            write_data,
    output logic [WORD_COUNT*WORD_SIZE-1:0] all_data_out,
    output logic [WORD_SIZE-1:0]            data_out,
    output logic                            ready,
    output logic                            busy,
    output logic [15:0]                     fetch_count
);
    localparam int OFF_W = $clog2(WORD_COUNT);
    localparam int BLK_W = WORD_COUNT * WORD_SIZE;
    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    logic [WORD_SIZE-1:0] mem [DEPTH];

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [OFF_W-1:0]      off_q, off_d;
    logic [15:0]           fc_q, fc_d;
    logic [BLK_W-1:0]      all_q, all_d;
    logic [WORD_SIZE-1:0]  dout_q, dout_d;

    logic                  mem_we;
    logic                  load;
    logic [ADDR_WIDTH-1:0] live_base;
    logic [ADDR_WIDTH-1:0] rd_base;
    logic [OFF_W-1:0]      rd_off;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [WORD_SIZE-1:0]  rd_word;
    logic [BLK_W-1:0]      rd_blk;

    // Power-up contents; reset deliberately leaves the array alone.
    initial begin
        for (int a = 0; a < DEPTH; a++) begin
            mem[a] = WORD_SIZE'(a) ^ DATA_SEED;
        end
    end

    assign live_base = {address[ADDR_WIDTH-1:OFF_W], OFF_W'(0)};
    assign mem_we    = write_enable && (state_q == IDLE);

    // Stores land only while idle; busy-time stores are dropped.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[address] <= write_data;
        end
    end

    // Gather the block; a same-edge store is forwarded so the
    // single-cycle fetch still sees the post-write word.
    always_comb begin
        rd_blk  = '0;
        rd_addr = '0;
        rd_word = '0;
        rd_base = (state_q == IDLE) ? live_base : base_q;
        rd_off  = (state_q == IDLE) ? address[OFF_W-1:0] : off_q;
        for (int i = 0; i < WORD_COUNT; i++) begin
            rd_addr = rd_base | ADDR_WIDTH'(i);
            rd_word = mem[rd_addr];
            if (mem_we && (rd_addr == address)) begin
                rd_word = write_data;
            end
            rd_blk[i*WORD_SIZE +: WORD_SIZE] = rd_word;
        end
    end

    // Next-state logic: accept, count down, respond, return to idle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        base_d  = base_q;
        off_d   = off_q;
        fc_d    = fc_q;
        all_d   = all_q;
        dout_d  = dout_q;
        load    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (read_enable) begin
                    base_d = live_base;
                    off_d  = address[OFF_W-1:0];
                    cnt_d  = 4'(READ_LATENCY - 1);
                    if (fc_q != 16'hFFFF) begin
                        fc_d = fc_q + 16'd1;
                    end
                    if (READ_LATENCY == 1) begin
                        state_d = RESP;
                        load    = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                    load    = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (load) begin
            all_d  = rd_blk;
            dout_d = rd_blk[rd_off*WORD_SIZE +: WORD_SIZE];
        end
    end

    // State and output registers; reset drops any in-flight fetch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            base_q  <= '0;
            off_q   <= '0;
            fc_q    <= '0;
            all_q   <= '0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            base_q  <= base_d;
            off_q   <= off_d;
            fc_q    <= fc_d;
            all_q   <= all_d;
            dout_q  <= dout_d;
        end
    end

    assign all_data_out = all_q;
    assign data_out     = dout_q;
    assign ready        = (state_q == RESP);
    assign busy         = (state_q != IDLE);
    assign fetch_count  = fc_q;
endmodule
